fifo_rd_burst_arbiter: RTL and testbench

//  Shares the read port of the async FIFO among Num_req consumers in the read-clock domain.

---
 rtl/fifo_rd_burst_arbiter_if.sv | 27 ++
 rtl/fifo_rd_burst_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fifo_rd_burst_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_burst_arbiter_if.sv
// rtl/fifo_rd_burst_arbiter_if.sv - FIFO read-port / consumer bundle for the burst arbiter
// master = arbiter side, slave = FIFO plus consumers side.
interface fifo_rd_burst_arbiter_if #(
    parameter int Num_req    = 4,
    parameter int Data_width = 8
);
    logic [Num_req-1:0]    Req;
    logic                  Rempty;
    logic [Data_width-1:0] Rdata;
    logic                  Rinc;
    logic [Num_req-1:0]    Gnt;
    logic [Data_width-1:0] Out_data;
    logic                  Out_valid;
    logic                  Burst_done;
    logic                  Busy;
    logic                  Timeout;

    modport master (
        input  Req, Rempty, Rdata,
        output Rinc, Gnt, Out_data, Out_valid, Burst_done, Busy, Timeout
    );

    modport slave (
        output Req, Rempty, Rdata,
        input  Rinc, Gnt, Out_data, Out_valid, Burst_done, Busy, Timeout
    );
endinterface

// File: rtl/fifo_rd_burst_arbiter.sv
// rtl/fifo_rd_burst_arbiter.sv - round-robin burst arbiter sharing an async FIFO read port
// Optional empty-stall abort enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_rd_burst_arbiter #(
    parameter int Num_req        = 4,
    parameter int Data_width     = 8,
    parameter int Burst_len      = 4,
    parameter int Timeout_cycles = 16
) (
    input  logic                    Rclk,
    input  logic                    Rrst,
    fifo_rd_burst_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(Num_req);
    localparam int CNT_W = $clog2(Burst_len + 1);

    typedef enum logic {IDLE, BURST} state_t;

    if (Num_req < 2 || Burst_len < 1 || Timeout_cycles < 1) begin : g_bad_params
        $error("fifo_rd_burst_arbiter: illegal parameter values");
    end

    state_t             state_q, state_d;
    logic [Num_req-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               burst_done_q, burst_done_d;
`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(Timeout_cycles + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_q, timeout_d;
`endif

    logic               rinc;
    logic               busy;
    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;

    // Search starts one past the previous holder so every requester gets a turn.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= Num_req; k++) begin
            cand     = (int'(last_ptr_q) + k) % Num_req;
            cand_idx = PTR_W'(cand);
            if (!pick_found && bus.Req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge Rclk) begin
        if (Rrst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            idx_q        <= '0;
            last_ptr_q   <= PTR_W'(Num_req - 1);
            count_q      <= '0;
            burst_done_q <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
            stall_q      <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            idx_q        <= idx_d;
            last_ptr_q   <= last_ptr_d;
            count_q      <= count_d;
            burst_done_q <= burst_done_d;
`ifdef FIFO_RD_TIMEOUT_EN
            stall_q      <= stall_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        idx_d        = idx_q;
        last_ptr_d   = last_ptr_q;
        count_d      = count_q;
        burst_done_d = 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
        stall_d      = stall_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d         = BURST;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    count_d         = '0;
`ifdef FIFO_RD_TIMEOUT_EN
                    stall_d         = '0;
`endif
                end
            end
            BURST: begin
                if (rinc) begin
`ifdef FIFO_RD_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (count_q == CNT_W'(Burst_len - 1)) begin
                        state_d      = IDLE;
                        gnt_d        = '0;
                        burst_done_d = 1'b1;
                        last_ptr_d   = idx_q;
                        count_d      = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
`ifdef FIFO_RD_TIMEOUT_EN
                // A starved holder forfeits its turn rather than blocking the others.
                else if (stall_q == STALL_W'(Timeout_cycles - 1)) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    timeout_d  = 1'b1;
                    last_ptr_d = idx_q;
                    count_d    = '0;
                    stall_d    = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Rinc is combinational on Rempty so a read never lands on an empty FIFO.
    always_comb begin
        rinc = 1'b0;
        busy = 1'b0;
        if (state_q == BURST) begin
            busy = 1'b1;
            rinc = !bus.Rempty;
        end
    end

    assign bus.Rinc       = rinc;
    assign bus.Busy       = busy;
    assign bus.Gnt        = gnt_q;
    assign bus.Out_data   = bus.Rdata;
    assign bus.Out_valid  = rinc;
    assign bus.Burst_done = burst_done_q;
`ifdef FIFO_RD_TIMEOUT_EN
    assign bus.Timeout    = timeout_q;
`else
    assign bus.Timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_burst_arbiter.sv
// tb/tb_fifo_rd_burst_arbiter.sv - directed self-checking bench for fifo_rd_burst_arbiter
// Covers FIFO_RD_TIMEOUT_EN when the macro is defined for the build.
module tb_fifo_rd_burst_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int TO = 16;

    logic          Rclk = 1'b0;
    logic          Rrst;
    logic [DW-1:0] fifo_rd = 8'd1;
    int            checks = 0;
    int            errors = 0;
    int            exp_word;

    fifo_rd_burst_arbiter_if #(.Num_req(NR), .Data_width(DW)) bus ();

    fifo_rd_burst_arbiter #(
        .Num_req(NR), .Data_width(DW), .Burst_len(BL), .Timeout_cycles(TO)
    ) dut (
        .Rclk(Rclk),
        .Rrst(Rrst),
        .bus (bus)
    );

    always #5 Rclk = ~Rclk;

    // FIFO model: head word increments by one on every accepted read.
    assign bus.Rdata = fifo_rd;
    always @(posedge Rclk) if (bus.Rinc) fifo_rd <= fifo_rd + 8'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Rclk);
        #1;
    endtask

    // Reset with Rempty high so no word is consumed; returns in the first cycle Gnt may be up.
    task automatic reset_dut(input logic [NR-1:0] req);
        Rrst       = 1'b1;
        bus.Req    = req;
        bus.Rempty = 1'b1;
        next_cycle();
        Rrst       = 1'b0;
        bus.Rempty = 1'b0;
        @(negedge Rclk);
        check("rst_gnt", bus.Gnt, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_rinc", bus.Rinc, 0);
        check("rst_done", bus.Burst_done, 0);
        check("rst_tmo", bus.Timeout, 0);
        next_cycle();
    endtask

    // Expects a full burst for exp_gnt starting this cycle, optionally stalling
    // stall_len cycles after word stall_after, and dropping own Req after word 1.
    task automatic expect_burst(input logic [NR-1:0] exp_gnt, input int stall_after,
                                input int stall_len, input bit drop);
        int   words;
        int   stall_left;
        int   cyc;
        logic exp_rinc;
        words      = 0;
        cyc        = 0;
        stall_left = (stall_after == 0) ? stall_len : 0;
        while (words < BL && cyc < 60) begin
            exp_rinc   = (stall_left == 0);
            bus.Rempty = !exp_rinc;
            if (stall_left > 0) stall_left--;
            @(negedge Rclk);
            check("gnt", bus.Gnt, exp_gnt);
            check("busy", bus.Busy, 1);
            check("rinc", bus.Rinc, exp_rinc);
            check("tmo", bus.Timeout, 0);
            if (cyc == 0) check("done_low", bus.Burst_done, 0);
            if (exp_rinc) begin
                check("data", bus.Out_data, exp_word[7:0]);
                check("valid", bus.Out_valid, 1);
                exp_word++;
                words++;
                if (words == stall_after) stall_left = stall_len;
                if (drop && words == 1) bus.Req = bus.Req & ~exp_gnt;
            end
            cyc++;
            next_cycle();
        end
        if (words < BL) check("burst_bound", words, BL);
        bus.Rempty = 1'b0;
        @(negedge Rclk);
        check("done_pulse", bus.Burst_done, 1);
        check("done_gnt", bus.Gnt, 0);
        check("done_busy", bus.Busy, 0);
        check("done_rinc", bus.Rinc, 0);
        next_cycle();
    endtask

    initial begin
        Rrst       = 1'b1;
        bus.Req    = '0;
        bus.Rempty = 1'b1;
        exp_word   = 1;

        reset_dut(4'b1111);
        expect_burst(4'b0001, 0, 0, 0);
        expect_burst(4'b0010, 0, 0, 0);

        reset_dut(4'b1001);
        expect_burst(4'b0001, 0, 0, 0);
        expect_burst(4'b1000, 0, 0, 0);
        expect_burst(4'b0001, 0, 0, 0);
        expect_burst(4'b1000, 0, 0, 0);

        reset_dut(4'b0100);
        expect_burst(4'b0100, 2, 3, 0);

        reset_dut(4'b0010);
        expect_burst(4'b0010, 0, 0, 1);
        @(negedge Rclk);
        check("idle_gnt", bus.Gnt, 0);
        check("idle_busy", bus.Busy, 0);
        next_cycle();

        reset_dut(4'b1111);
        @(negedge Rclk);
        check("mid_gnt", bus.Gnt, 4'b0001);
        check("mid_w1", bus.Out_data, exp_word[7:0]);
        exp_word++;
        next_cycle();
        Rrst = 1'b1;
        @(negedge Rclk);
        check("mid_w2_rinc", bus.Rinc, 1);
        check("mid_w2", bus.Out_data, exp_word[7:0]);
        exp_word++;
        next_cycle();
        Rrst = 1'b0;
        @(negedge Rclk);
        check("abort_gnt", bus.Gnt, 0);
        check("abort_rinc", bus.Rinc, 0);
        check("abort_busy", bus.Busy, 0);
        next_cycle();
        expect_burst(4'b0001, 0, 0, 0);

        reset_dut(4'b0011);
`ifdef FIFO_RD_TIMEOUT_EN
        bus.Rempty = 1'b1;
        for (int c = 0; c < TO; c++) begin
            @(negedge Rclk);
            check("stall_gnt", bus.Gnt, 4'b0001);
            check("stall_rinc", bus.Rinc, 0);
            check("stall_tmo", bus.Timeout, 0);
            next_cycle();
        end
        @(negedge Rclk);
        check("tmo_pulse", bus.Timeout, 1);
        check("tmo_gnt", bus.Gnt, 0);
        check("tmo_done", bus.Burst_done, 0);
        check("tmo_rinc", bus.Rinc, 0);
        next_cycle();
        expect_burst(4'b0010, 0, 0, 0);
`else
        expect_burst(4'b0001, 0, 20, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
